// File: rtl/axi_common_types_pkg.sv
// -----------------------------------------------------------------------------
// axi_common_types_pkg
// Shared AXI constants for the NoC initiator: field widths, response and burst
// encodings, the initiator FSM state type and the 4 KB boundary helper.
// No ports (package).
// -----------------------------------------------------------------------------
package axi_common_types_pkg;

   localparam int AXI_SID_WIDTH  = 4;
   localparam int AXI_ID_WIDTH   = AXI_SID_WIDTH;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AW   = 3'd1,
      ST_W    = 3'd2,
      ST_B    = 3'd3,
      ST_AR   = 3'd4,
      ST_R    = 3'd5,
      ST_ERR  = 3'd6
   } axi_init_state_e;

   // True when a burst starting at page offset offs with len+1 beats of
   // strb_w bytes would run past the end of its 4 KB page.
   function automatic logic crosses_4k(input logic [11:0] offs,
                                       input logic [3:0]  len,
                                       input int unsigned strb_w);
      logic [16:0] span;
      logic [16:0] end_offs;
      span     = (17'(len) + 17'd1) * 17'(strb_w);
      end_offs = 17'(offs) + span;
      return (end_offs > 17'd4096);
   endfunction

endpackage

// File: rtl/axi_beat_ctr.sv
// -----------------------------------------------------------------------------
// axi_beat_ctr
// 4-bit burst beat counter: cleared while clr_i is high, increments on each
// data handshake, flags the final beat of a burst.
// Ports:
//   clk_i   in  clock (posedge)
//   rst_i   in  synchronous active-high reset
//   clr_i   in  clear counter to 0
//   inc_i   in  advance by one (data handshake)
//   len_i   in  burst length minus one
//   last_o  out current beat is the last one (count == len)
// -----------------------------------------------------------------------------
module axi_beat_ctr (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       inc_i,
   input  logic [3:0] len_i,
   output logic       last_o
);

   logic [3:0] count_q;
   logic [3:0] count_d;

   // Next count: clear has priority over increment.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 4'd0;
      end else if (inc_i) begin
         count_d = count_q + 4'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last_o = (count_q == len_i);

endmodule

// File: rtl/axi_burst_initiator.sv
// -----------------------------------------------------------------------------
// axi_burst_initiator
// Single-outstanding AXI initiator: turns one command into an AW/W/B or AR/R
// burst on the master port, streams write data in and read data out, and
// reports a one-cycle completion (ID + response) per command.
// Ports:
//   ACLK, ARESET               clock, synchronous active-high reset
//   cmd_*                      command handshake (write/read, id, addr, len)
//   wr_*                       write-data stream into the burst
//   rd_*                       read-data stream out of the burst
//   done_*                     registered completion pulse
//   proto_err                  registered pulse on slave protocol violation
//   M_AW*/M_W*/M_B*            AXI write channels
//   M_AR*/M_R*                 AXI read channels
//   M_Ax{SIZE..USER}           constant burst attributes
// -----------------------------------------------------------------------------
module axi_burst_initiator
   import axi_common_types_pkg::*;
#(
   parameter  int ID_W   = AXI_ID_WIDTH,
   parameter  int ADDR_W = AXI_ADDR_WIDTH,
   parameter  int DATA_W = AXI_DATA_WIDTH,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              cmd_valid,
   input  logic              cmd_write,
   input  logic [ID_W-1:0]   cmd_id,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [3:0]        cmd_len,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [STRB_W-1:0] wr_strb,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              done_valid,
   output logic [ID_W-1:0]   done_id,
   output logic [1:0]        done_resp,
   output logic              proto_err,
   output logic [ID_W-1:0]   M_AWID,
   output logic [ADDR_W-1:0] M_AWADDR,
   output logic [3:0]        M_AWLEN,
   output logic              M_AWVALID,
   input  logic              M_AWREADY,
   output logic [2:0]        M_AWSIZE,
   output logic [1:0]        M_AWBURST,
   output logic [3:0]        M_AWCACHE,
   output logic [2:0]        M_AWPROT,
   output logic              M_AWLOCK,
   output logic [3:0]        M_AWQOS,
   output logic [3:0]        M_AWREGION,
   output logic              M_AWUSER,
   output logic [DATA_W-1:0] M_WDATA,
   output logic [STRB_W-1:0] M_WSTRB,
   output logic              M_WLAST,
   output logic              M_WVALID,
   input  logic              M_WREADY,
   input  logic [ID_W-1:0]   M_BID,
   input  logic [1:0]        M_BRESP,
   input  logic              M_BVALID,
   output logic              M_BREADY,
   output logic [ID_W-1:0]   M_ARID,
   output logic [ADDR_W-1:0] M_ARADDR,
   output logic [3:0]        M_ARLEN,
   output logic              M_ARVALID,
   input  logic              M_ARREADY,
   output logic [2:0]        M_ARSIZE,
   output logic [1:0]        M_ARBURST,
   output logic [3:0]        M_ARCACHE,
   output logic [2:0]        M_ARPROT,
   output logic              M_ARLOCK,
   output logic [3:0]        M_ARQOS,
   output logic [3:0]        M_ARREGION,
   output logic              M_ARUSER,
   input  logic [ID_W-1:0]   M_RID,
   input  logic [DATA_W-1:0] M_RDATA,
   input  logic [1:0]        M_RRESP,
   input  logic              M_RLAST,
   input  logic              M_RVALID,
   output logic              M_RREADY
);

   localparam int                SIZE_LOG2 = $clog2(STRB_W);
   localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'(STRB_W - 1);

   axi_init_state_e   state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        len_q, len_d;
   logic [1:0]        resp_q, resp_d;
   logic              id_err_q, id_err_d;
   logic              done_valid_q, done_valid_d;
   logic [ID_W-1:0]   done_id_q, done_id_d;
   logic [1:0]        done_resp_q, done_resp_d;
   logic              proto_err_q, proto_err_d;

   logic [ADDR_W-1:0] cmd_addr_aligned_s;
   logic              in_w_s, in_r_s;
   logic              w_hs_s, r_hs_s;
   logic              beat_last_s;

   assign cmd_addr_aligned_s = cmd_addr & ~LSB_MASK;
   assign in_w_s             = (state_q == ST_W);
   assign in_r_s             = (state_q == ST_R);
   assign w_hs_s             = in_w_s && wr_valid && M_WREADY;
   assign r_hs_s             = in_r_s && M_RVALID && rd_ready;

   axi_beat_ctr u_beat_ctr (
      .clk_i  (ACLK),
      .rst_i  (ARESET),
      .clr_i  (state_q == ST_IDLE),
      .inc_i  (w_hs_s || r_hs_s),
      .len_i  (len_q),
      .last_o (beat_last_s)
   );

   // Next-state and completion/status logic.
   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      addr_d       = addr_q;
      len_d        = len_q;
      resp_d       = resp_q;
      id_err_d     = id_err_q;
      done_valid_d = 1'b0;
      done_id_d    = done_id_q;
      done_resp_d  = done_resp_q;
      proto_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               id_d     = cmd_id;
               addr_d   = cmd_addr_aligned_s;
               len_d    = cmd_len;
               resp_d   = RESP_OKAY;
               id_err_d = 1'b0;
               if (crosses_4k(cmd_addr_aligned_s[11:0], cmd_len, STRB_W)) begin
                  state_d = ST_ERR;
               end else if (cmd_write) begin
                  state_d = ST_AW;
               end else begin
                  state_d = ST_AR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_AW: begin
            if (M_AWREADY) begin
               state_d = ST_W;
            end else begin
               state_d = ST_AW;
            end
         end
         ST_W: begin
            if (w_hs_s && beat_last_s) begin
               state_d = ST_B;
            end else begin
               state_d = ST_W;
            end
         end
         ST_B: begin
            if (M_BVALID) begin
               state_d      = ST_IDLE;
               done_valid_d = 1'b1;
               done_id_d    = id_q;
               if (M_BID != id_q) begin
                  done_resp_d = RESP_SLVERR;
                  proto_err_d = 1'b1;
               end else begin
                  done_resp_d = M_BRESP;
               end
            end else begin
               state_d = ST_B;
            end
         end
         ST_AR: begin
            if (M_ARREADY) begin
               state_d = ST_R;
            end else begin
               state_d = ST_AR;
            end
         end
         ST_R: begin
            if (r_hs_s) begin
               // Only the first non-OKAY response is kept.
               if ((resp_q == RESP_OKAY) && (M_RRESP != RESP_OKAY)) begin
                  resp_d = M_RRESP;
               end else begin
                  resp_d = resp_q;
               end
               if (M_RID != id_q) begin
                  id_err_d = 1'b1;
               end else begin
                  id_err_d = id_err_q;
               end
               proto_err_d = (M_RID != id_q) || (M_RLAST != beat_last_s);
               // The slave's RLAST ends the burst even if it disagrees with len.
               if (M_RLAST) begin
                  state_d      = ST_IDLE;
                  done_valid_d = 1'b1;
                  done_id_d    = id_q;
                  if (id_err_d) begin
                     done_resp_d = RESP_SLVERR;
                  end else begin
                     done_resp_d = resp_d;
                  end
               end else begin
                  state_d = ST_R;
               end
            end else begin
               state_d = ST_R;
            end
         end
         ST_ERR: begin
            state_d      = ST_IDLE;
            done_valid_d = 1'b1;
            done_id_d    = id_q;
            done_resp_d  = RESP_SLVERR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and status registers; reset abandons any burst without a done pulse.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= ST_IDLE;
         id_q         <= {ID_W{1'b0}};
         addr_q       <= {ADDR_W{1'b0}};
         len_q        <= 4'd0;
         resp_q       <= RESP_OKAY;
         id_err_q     <= 1'b0;
         done_valid_q <= 1'b0;
         done_id_q    <= {ID_W{1'b0}};
         done_resp_q  <= RESP_OKAY;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         resp_q       <= resp_d;
         id_err_q     <= id_err_d;
         done_valid_q <= done_valid_d;
         done_id_q    <= done_id_d;
         done_resp_q  <= done_resp_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign cmd_ready  = (state_q == ST_IDLE) && !ARESET;
   assign done_valid = done_valid_q;
   assign done_id    = done_id_q;
   assign done_resp  = done_resp_q;
   assign proto_err  = proto_err_q;

   // Address channels: payload comes from latched registers, so it is stable
   // for the whole time VALID is held.
   assign M_AWVALID = (state_q == ST_AW);
   assign M_AWID    = id_q;
   assign M_AWADDR  = addr_q;
   assign M_AWLEN   = len_q;
   assign M_ARVALID = (state_q == ST_AR);
   assign M_ARID    = id_q;
   assign M_ARADDR  = addr_q;
   assign M_ARLEN   = len_q;

   // Data channels are zero-latency pass-throughs, gated by state.
   assign M_WVALID = in_w_s && wr_valid;
   assign wr_ready = in_w_s && M_WREADY;
   assign M_WDATA  = in_w_s ? wr_data : {DATA_W{1'b0}};
   assign M_WSTRB  = in_w_s ? wr_strb : {STRB_W{1'b0}};
   assign M_WLAST  = in_w_s && beat_last_s;
   assign M_BREADY = (state_q == ST_B);
   assign M_RREADY = in_r_s && rd_ready;
   assign rd_valid = in_r_s && M_RVALID;
   assign rd_data  = in_r_s ? M_RDATA : {DATA_W{1'b0}};
   assign rd_last  = in_r_s && beat_last_s;

   assign M_AWSIZE   = 3'(SIZE_LOG2);
   assign M_AWBURST  = BURST_INCR;
   assign M_AWCACHE  = 4'd0;
   assign M_AWPROT   = 3'd0;
   assign M_AWLOCK   = 1'b0;
   assign M_AWQOS    = 4'd0;
   assign M_AWREGION = 4'd0;
   assign M_AWUSER   = 1'b0;
   assign M_ARSIZE   = 3'(SIZE_LOG2);
   assign M_ARBURST  = BURST_INCR;
   assign M_ARCACHE  = 4'd0;
   assign M_ARPROT   = 3'd0;
   assign M_ARLOCK   = 1'b0;
   assign M_ARQOS    = 4'd0;
   assign M_ARREGION = 4'd0;
   assign M_ARUSER   = 1'b0;

endmodule

// File: tb/tb_axi_burst_initiator.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_initiator
// Directed bench: a table of commands driven through a small in-bench slave,
// plus hand-written sequences for response, RLAST, ID and reset corner cases.
// -----------------------------------------------------------------------------
module tb_axi_burst_initiator;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid, cmd_write;
   logic [3:0]  cmd_id;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic        cmd_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_last, rd_valid, rd_ready;
   logic        done_valid;
   logic [3:0]  done_id;
   logic [1:0]  done_resp;
   logic        proto_err;
   logic [3:0]  M_AWID, M_AWLEN, M_AWCACHE, M_AWQOS, M_AWREGION;
   logic [31:0] M_AWADDR;
   logic        M_AWVALID, M_AWREADY, M_AWLOCK, M_AWUSER;
   logic [2:0]  M_AWSIZE, M_AWPROT;
   logic [1:0]  M_AWBURST;
   logic [31:0] M_WDATA;
   logic [3:0]  M_WSTRB;
   logic        M_WLAST, M_WVALID, M_WREADY;
   logic [3:0]  M_BID;
   logic [1:0]  M_BRESP;
   logic        M_BVALID, M_BREADY;
   logic [3:0]  M_ARID, M_ARLEN, M_ARCACHE, M_ARQOS, M_ARREGION;
   logic [31:0] M_ARADDR;
   logic        M_ARVALID, M_ARREADY, M_ARLOCK, M_ARUSER;
   logic [2:0]  M_ARSIZE, M_ARPROT;
   logic [1:0]  M_ARBURST;
   logic [3:0]  M_RID;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RLAST, M_RVALID, M_RREADY;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 ACLK = ~ACLK;

   axi_burst_initiator #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_id(cmd_id),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done_valid(done_valid), .done_id(done_id), .done_resp(done_resp),
      .proto_err(proto_err),
      .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
      .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
      .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWCACHE(M_AWCACHE),
      .M_AWPROT(M_AWPROT), .M_AWLOCK(M_AWLOCK), .M_AWQOS(M_AWQOS),
      .M_AWREGION(M_AWREGION), .M_AWUSER(M_AWUSER),
      .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
      .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
      .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
      .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
      .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
      .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARCACHE(M_ARCACHE),
      .M_ARPROT(M_ARPROT), .M_ARLOCK(M_ARLOCK), .M_ARQOS(M_ARQOS),
      .M_ARREGION(M_ARREGION), .M_ARUSER(M_ARUSER),
      .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
      .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
   );

   typedef struct {
      logic        write;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic        toggle;
      logic        exp_err;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one cycle; drive and sample 2 time units after the rising edge.
   task automatic tick();
      @(posedge ACLK);
      #2;
   endtask

   task automatic issue_cmd(input logic w, input logic [3:0] id,
                            input logic [31:0] addr, input logic [3:0] len);
      cmd_valid = 1'b1; cmd_write = w; cmd_id = id; cmd_addr = addr; cmd_len = len;
      #1;
      chk("cmd_ready_idle", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   // Address phase with one stall cycle before READY.
   task automatic addr_phase(input logic w, input logic [3:0] id,
                             input logic [31:0] exp_addr, input logic [3:0] len);
      #1;
      chk("addr_valid_stall", w ? M_AWVALID : M_ARVALID, 1'b1);
      chk("other_addr_valid", w ? M_ARVALID : M_AWVALID, 1'b0);
      tick();
      if (w) M_AWREADY = 1'b1; else M_ARREADY = 1'b1;
      #1;
      chk("addr_valid_held", w ? M_AWVALID : M_ARVALID, 1'b1);
      chk("addr_value", w ? M_AWADDR : M_ARADDR, exp_addr);
      chk("addr_len", w ? M_AWLEN : M_ARLEN, len);
      chk("addr_id", w ? M_AWID : M_ARID, id);
      tick();
      M_AWREADY = 1'b0; M_ARREADY = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] exp_addr,
                           input logic [3:0] len, input logic [3:0] bid,
                           input logic [1:0] bresp, input logic [1:0] exp_resp,
                           input logic exp_pe);
      addr_phase(1'b1, id, exp_addr, len);
      // One cycle with no write data offered.
      wr_valid = 1'b0; M_WREADY = 1'b1;
      #1;
      chk("wvalid_gap", M_WVALID, 1'b0);
      tick();
      for (int b = 0; b <= int'(len); b++) begin
         wr_valid = 1'b1; wr_data = 32'h0000_00A0 + 32'(b); wr_strb = 4'(b) ^ 4'hF;
         #1;
         chk("wvalid", M_WVALID, 1'b1);
         chk("wready", wr_ready, 1'b1);
         chk("wdata", M_WDATA, 32'h0000_00A0 + 32'(b));
         chk("wstrb", M_WSTRB, 4'(b) ^ 4'hF);
         chk("wlast", M_WLAST, (b == int'(len)));
         tick();
      end
      wr_valid = 1'b0; M_WREADY = 1'b0;
      #1;
      chk("bready", M_BREADY, 1'b1);
      chk("wvalid_after", M_WVALID, 1'b0);
      M_BVALID = 1'b1; M_BID = bid; M_BRESP = bresp;
      tick();
      M_BVALID = 1'b0;
      #1;
      chk("wr_done_valid", done_valid, 1'b1);
      chk("wr_done_id", done_id, id);
      chk("wr_done_resp", done_resp, exp_resp);
      chk("wr_proto_err", proto_err, exp_pe);
      chk("wr_cmd_ready_at_done", cmd_ready, 1'b1);
      chk("bready_after", M_BREADY, 1'b0);
      tick();
      chk("wr_done_pulse_end", done_valid, 1'b0);
      chk("wr_proto_err_end", proto_err, 1'b0);
   endtask

   // Read burst against a slave that returns RLAST on beat last_beat and the
   // per-beat responses packed 2 bits per beat in resp_seq.
   task automatic do_read(input logic [3:0] id, input logic [31:0] exp_addr,
                          input logic [3:0] len, input logic [3:0] rid,
                          input logic [31:0] resp_seq, input int last_beat,
                          input logic toggle, input logic [1:0] exp_resp);
      int   b;
      logic pe_exp;
      logic fin;
      logic rr;
      b = 0; pe_exp = 1'b0; fin = 1'b0;
      addr_phase(1'b0, id, exp_addr, len);
      for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
         rr = toggle ? ~cyc[0] : 1'b1;
         M_RVALID = 1'b1; M_RID = rid; M_RDATA = 32'hD000_0000 + 32'(b);
         M_RRESP = resp_seq[2*b +: 2]; M_RLAST = (b == last_beat); rd_ready = rr;
         #1;
         chk("rd_valid", rd_valid, 1'b1);
         chk("rd_data", rd_data, 32'hD000_0000 + 32'(b));
         chk("rd_last", rd_last, (4'(b) == len));
         chk("rready", M_RREADY, rr);
         chk("rd_proto_err", proto_err, pe_exp);
         pe_exp = rr && (((b == last_beat) != (4'(b) == len)) || (rid != id));
         if (rr && (b == last_beat)) fin = 1'b1;
         if (rr) b++;
         tick();
      end
      M_RVALID = 1'b0; M_RLAST = 1'b0; rd_ready = 1'b0;
      if (!fin) begin
         n_chk++;
         n_fail++;
         $display("FAIL read_timeout: burst got %0d beats, required %0d", b, last_beat + 1);
      end
      #1;
      chk("rd_done_valid", done_valid, 1'b1);
      chk("rd_done_id", done_id, id);
      chk("rd_done_resp", done_resp, exp_resp);
      chk("rd_done_proto_err", proto_err, pe_exp);
      chk("rd_cmd_ready_at_done", cmd_ready, 1'b1);
      chk("rready_after", M_RREADY, 1'b0);
      tick();
      chk("rd_done_pulse_end", done_valid, 1'b0);
      chk("rd_proto_err_end", proto_err, 1'b0);
   endtask

   initial begin
      ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = 4'h0;
      cmd_addr = 32'h0; cmd_len = 4'h0; wr_data = 32'h0; wr_strb = 4'h0;
      wr_valid = 1'b0; rd_ready = 1'b0; M_AWREADY = 1'b0; M_WREADY = 1'b0;
      M_BID = 4'h0; M_BRESP = 2'b00; M_BVALID = 1'b0; M_ARREADY = 1'b0;
      M_RID = 4'h0; M_RDATA = 32'h0; M_RRESP = 2'b00; M_RLAST = 1'b0; M_RVALID = 1'b0;

      //            write  id     addr          len    tgl   err   exp_addr
      vecs[0] = '{1'b1, 4'h5, 32'h0000_0100, 4'd3,  1'b0, 1'b0, 32'h0000_0100};
      vecs[1] = '{1'b1, 4'h3, 32'h0000_0FF8, 4'd3,  1'b0, 1'b1, 32'h0000_0FF8};
      vecs[2] = '{1'b0, 4'h9, 32'h0000_2000, 4'd7,  1'b1, 1'b0, 32'h0000_2000};
      vecs[3] = '{1'b0, 4'h2, 32'h0000_0FF0, 4'd3,  1'b0, 1'b0, 32'h0000_0FF0};
      vecs[4] = '{1'b1, 4'h1, 32'h0000_0FF3, 4'd0,  1'b0, 1'b0, 32'h0000_0FF0};
      vecs[5] = '{1'b0, 4'h7, 32'h0000_1FFC, 4'd1,  1'b0, 1'b1, 32'h0000_1FFC};
      vecs[6] = '{1'b1, 4'hF, 32'h0000_3000, 4'd15, 1'b0, 1'b0, 32'h0000_3000};

      // Reset state, including cmd_ready held low while ARESET is high.
      tick();
      tick();
      #1;
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_awvalid", M_AWVALID, 1'b0);
      chk("rst_arvalid", M_ARVALID, 1'b0);
      chk("rst_wvalid", M_WVALID, 1'b0);
      chk("rst_bready", M_BREADY, 1'b0);
      chk("rst_rready", M_RREADY, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_done_valid", done_valid, 1'b0);
      chk("rst_proto_err", proto_err, 1'b0);
      ARESET = 1'b0;
      #1;
      chk("cmd_ready_after_rst", cmd_ready, 1'b1);
      chk("awsize", M_AWSIZE, 3'd2);
      chk("arsize", M_ARSIZE, 3'd2);
      chk("awburst", M_AWBURST, 2'b01);
      chk("arburst", M_ARBURST, 2'b01);
      chk("attr_zero", {M_AWCACHE, M_AWPROT, M_AWLOCK, M_AWQOS, M_AWREGION, M_AWUSER,
                        M_ARCACHE, M_ARPROT, M_ARLOCK, M_ARQOS, M_ARREGION, M_ARUSER}, 64'd0);
      tick();

      // Table-driven commands.
      for (int i = 0; i < 7; i++) begin
         issue_cmd(vecs[i].write, vecs[i].id, vecs[i].addr, vecs[i].len);
         if (vecs[i].exp_err) begin
            #1;
            chk("err_no_awvalid", M_AWVALID, 1'b0);
            chk("err_no_arvalid", M_ARVALID, 1'b0);
            chk("err_cmd_ready", cmd_ready, 1'b0);
            chk("err_done_early", done_valid, 1'b0);
            tick();
            chk("err_done_valid", done_valid, 1'b1);
            chk("err_done_resp", done_resp, 2'b10);
            chk("err_no_awvalid2", M_AWVALID, 1'b0);
            chk("err_cmd_ready_at_done", cmd_ready, 1'b1);
            tick();
            chk("err_done_pulse_end", done_valid, 1'b0);
         end else if (vecs[i].write) begin
            do_write(vecs[i].id, vecs[i].exp_addr, vecs[i].len, vecs[i].id,
                     2'b00, 2'b00, 1'b0);
         end else begin
            do_read(vecs[i].id, vecs[i].exp_addr, vecs[i].len, vecs[i].id,
                    32'h0, int'(vecs[i].len), vecs[i].toggle, 2'b00);
         end
      end

      // Read responses OKAY, DECERR, OKAY: first non-OKAY is reported.
      issue_cmd(1'b0, 4'h4, 32'h0000_0040, 4'd2);
      do_read(4'h4, 32'h0000_0040, 4'd2, 4'h4, 32'h0000_000C, 2, 1'b0, 2'b11);

      // RLAST early on beat 1 of a 4-beat read.
      issue_cmd(1'b0, 4'h8, 32'h0000_0080, 4'd3);
      do_read(4'h8, 32'h0000_0080, 4'd3, 4'h8, 32'h0, 1, 1'b0, 2'b00);

      // Final beat count reached without RLAST; slave ends one beat later.
      issue_cmd(1'b0, 4'hA, 32'h0000_00C0, 4'd1);
      do_read(4'hA, 32'h0000_00C0, 4'd1, 4'hA, 32'h0, 2, 1'b0, 2'b00);

      // Wrong RID forces SLVERR and flags every beat.
      issue_cmd(1'b0, 4'hB, 32'h0000_0200, 4'd1);
      do_read(4'hB, 32'h0000_0200, 4'd1, 4'hC, 32'h0, 1, 1'b0, 2'b10);

      // Write: BRESP DECERR passes through; wrong BID forces SLVERR.
      issue_cmd(1'b1, 4'h6, 32'h0000_0300, 4'd1);
      do_write(4'h6, 32'h0000_0300, 4'd1, 4'h6, 2'b11, 2'b11, 1'b0);
      issue_cmd(1'b1, 4'h2, 32'h0000_0304, 4'd0);
      do_write(4'h2, 32'h0000_0304, 4'd0, 4'h3, 2'b00, 2'b10, 1'b1);

      // Reset during W beat 2 abandons the burst with no done pulse.
      issue_cmd(1'b1, 4'h6, 32'h0000_0400, 4'd3);
      M_AWREADY = 1'b1;
      tick();
      M_AWREADY = 1'b0;
      wr_valid = 1'b1; M_WREADY = 1'b1; wr_data = 32'h0000_00B0;
      tick();
      wr_data = 32'h0000_00B1;
      tick();
      ARESET = 1'b1; wr_data = 32'h0000_00B2;
      #1;
      chk("mid_rst_wvalid_before", M_WVALID, 1'b1);
      tick();
      ARESET = 1'b0;
      #1;
      chk("mid_rst_wvalid", M_WVALID, 1'b0);
      chk("mid_rst_wr_ready", wr_ready, 1'b0);
      chk("mid_rst_wlast", M_WLAST, 1'b0);
      chk("mid_rst_awvalid", M_AWVALID, 1'b0);
      chk("mid_rst_bready", M_BREADY, 1'b0);
      chk("mid_rst_rready", M_RREADY, 1'b0);
      chk("mid_rst_rd_valid", rd_valid, 1'b0);
      chk("mid_rst_done_valid", done_valid, 1'b0);
      chk("mid_rst_proto_err", proto_err, 1'b0);
      chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
      wr_valid = 1'b0; M_WREADY = 1'b0;
      tick();
      chk("mid_rst_no_done", done_valid, 1'b0);
      issue_cmd(1'b1, 4'hD, 32'h0000_0500, 4'd2);
      do_write(4'hD, 32'h0000_0500, 4'd2, 4'hD, 2'b00, 2'b00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
